// File: rtl/cm0_dap_cdc_mask_ctrl.sv
`default_nettype none
// cm0_dap_cdc_mask_ctrl: source-side REQ/ACK + AND-mask sequencer for a 4-bit masked CDC crossing.
// Revision: 1.0

module cm0_dap_cdc_mask_ctrl #(
   parameter int PRESENT     = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic       DCLK,
   input  logic       DPRESETn,
   input  logic       LOAD_VALID,
   input  logic [3:0] LOAD_DATA,
   output logic       LOAD_READY,
   input  logic       ABORT,
   output logic [3:0] CDC_DATA,
   output logic       CDC_MASKn,
   output logic       CDC_REQ,
   input  logic       CDC_ACK,
   output logic       BUSY,
   output logic       DONE
);

   generate
      if (PRESENT != 0) begin : g_present
         localparam logic [1:0] ST_IDLE    = 2'd0;
         localparam logic [1:0] ST_SETUP   = 2'd1;
         localparam logic [1:0] ST_REQ     = 2'd2;
         localparam logic [1:0] ST_ACKWAIT = 2'd3;

         logic [1:0]             state;
         logic [1:0]             state_nxt;
         logic [SYNC_STAGES-1:0] ack_sync;
         logic                   ack_s;
         logic                   load_ready;
         logic                   load_take;
         logic [3:0]             data_q;
         logic                   mask_q;
         logic                   req_q;
         logic                   busy_q;
         logic                   done_q;

         assign ack_s      = ack_sync[SYNC_STAGES-1];
         // A stale ACK left over from before a reset must clear before the next load.
         assign load_ready = (state == ST_IDLE) & ~ack_s;
         assign load_take  = LOAD_VALID & load_ready;

         always_comb begin
            state_nxt = state;
            case (state)
               ST_IDLE:    if (load_take) state_nxt = ST_SETUP;
               ST_SETUP:   state_nxt = ABORT ? ST_IDLE : ST_REQ;
               ST_REQ:     if (ack_s) state_nxt = ST_ACKWAIT;
               ST_ACKWAIT: if (!ack_s) state_nxt = ST_IDLE;
               default:    state_nxt = ST_IDLE;
            endcase
         end

         // Mask and request are registered from the next state so they rise and fall together.
         always_ff @(posedge DCLK) begin
            if (!DPRESETn) begin
               state    <= ST_IDLE;
               ack_sync <= '0;
               data_q   <= 4'h0;
               mask_q   <= 1'b0;
               req_q    <= 1'b0;
               busy_q   <= 1'b0;
               done_q   <= 1'b0;
            end else begin
               state    <= state_nxt;
               ack_sync <= {ack_sync[SYNC_STAGES-2:0], CDC_ACK};
               if (load_take) data_q <= LOAD_DATA;
               mask_q   <= (state_nxt == ST_REQ);
               req_q    <= (state_nxt == ST_REQ);
               busy_q   <= (state_nxt != ST_IDLE);
               done_q   <= (state == ST_ACKWAIT) & ~ack_s;
            end
         end

         assign LOAD_READY = load_ready;
         assign CDC_DATA   = data_q;
         assign CDC_MASKn  = mask_q;
         assign CDC_REQ    = req_q;
         assign BUSY       = busy_q;
         assign DONE       = done_q;
      end else begin : g_absent
         logic unused_inputs;
         assign unused_inputs = ^{DCLK, DPRESETn, LOAD_VALID, LOAD_DATA, ABORT, CDC_ACK};
         assign LOAD_READY = 1'b0;
         assign CDC_DATA   = 4'h0;
         assign CDC_MASKn  = 1'b0;
         assign CDC_REQ    = 1'b0;
         assign BUSY       = 1'b0;
         assign DONE       = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_cm0_dap_cdc_mask_ctrl.sv
`default_nettype none
// tb_cm0_dap_cdc_mask_ctrl: directed self-checking bench for the masked CDC source controller.
// Revision: 1.0

module tb_cm0_dap_cdc_mask_ctrl;

   logic       DCLK;
   logic       DPRESETn;
   logic       LOAD_VALID;
   logic [3:0] LOAD_DATA;
   logic       LOAD_READY;
   logic       ABORT;
   logic [3:0] CDC_DATA;
   logic       CDC_MASKn;
   logic       CDC_REQ;
   logic       CDC_ACK;
   logic       BUSY;
   logic       DONE;

   logic       ack_loop;
   logic       ack_force;

   logic       p0_rstn;
   logic       p0_valid;
   logic [3:0] p0_data;
   logic       p0_ready;
   logic       p0_abort;
   logic [3:0] p0_cdc_data;
   logic       p0_maskn;
   logic       p0_req;
   logic       p0_ack;
   logic       p0_busy;
   logic       p0_done;

   int tests = 0;
   int fails = 0;
   logic       chk_en = 1'b0;
   logic [3:0] prev_data;

   assign CDC_ACK = ack_loop ? CDC_REQ : ack_force;

   cm0_dap_cdc_mask_ctrl #(.PRESENT(1), .SYNC_STAGES(2)) dut (
      .DCLK(DCLK), .DPRESETn(DPRESETn), .LOAD_VALID(LOAD_VALID), .LOAD_DATA(LOAD_DATA),
      .LOAD_READY(LOAD_READY), .ABORT(ABORT), .CDC_DATA(CDC_DATA), .CDC_MASKn(CDC_MASKn),
      .CDC_REQ(CDC_REQ), .CDC_ACK(CDC_ACK), .BUSY(BUSY), .DONE(DONE)
   );

   cm0_dap_cdc_mask_ctrl #(.PRESENT(0), .SYNC_STAGES(2)) dut_absent (
      .DCLK(DCLK), .DPRESETn(p0_rstn), .LOAD_VALID(p0_valid), .LOAD_DATA(p0_data),
      .LOAD_READY(p0_ready), .ABORT(p0_abort), .CDC_DATA(p0_cdc_data), .CDC_MASKn(p0_maskn),
      .CDC_REQ(p0_req), .CDC_ACK(p0_ack), .BUSY(p0_busy), .DONE(p0_done)
   );

   initial DCLK = 1'b0;
   always #5 DCLK = ~DCLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   // Continuous invariant monitor, sampled mid-cycle.
   always @(negedge DCLK) begin
      if (chk_en) begin
         tests = tests + 1;
         assert (CDC_MASKn === CDC_REQ) else begin
            fails = fails + 1;
            $error("FAIL mask_req_together: CDC_MASKn=%0b CDC_REQ=%0b", CDC_MASKn, CDC_REQ);
         end
         if (CDC_MASKn === 1'b1) begin
            tests = tests + 1;
            assert (CDC_DATA === prev_data) else begin
               fails = fails + 1;
               $error("FAIL data_stable_masked: got %0h want %0h", CDC_DATA, prev_data);
            end
         end
      end
      prev_data = CDC_DATA;
   end

   task automatic tick();
      @(posedge DCLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests = tests + 1;
      assert (got === exp) else begin
         fails = fails + 1;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Looped-back transfer: data after T0, REQ/MASKn high after T1..T3, low from T4, DONE after T7.
   task automatic do_xfer(input logic [3:0] d, input logic ab);
      chk("ready_before_load", {7'b0, LOAD_READY}, 8'h1);
      LOAD_VALID = 1'b1;
      LOAD_DATA  = d;
      ABORT      = ab;
      tick();
      LOAD_VALID = 1'b0;
      ABORT      = 1'b0;
      LOAD_DATA  = ~d;
      chk("t0_data",  {4'b0, CDC_DATA}, {4'b0, d});
      chk("t0_busy",  {7'b0, BUSY}, 8'h1);
      chk("t0_maskn", {7'b0, CDC_MASKn}, 8'h0);
      chk("t0_ready", {7'b0, LOAD_READY}, 8'h0);
      for (int e = 1; e <= 7; e++) begin
         tick();
         chk("xfer_maskn", {7'b0, CDC_MASKn}, {7'b0, (e <= 3)});
         chk("xfer_req",   {7'b0, CDC_REQ},   {7'b0, (e <= 3)});
         chk("xfer_done",  {7'b0, DONE},      {7'b0, (e == 7)});
         chk("xfer_busy",  {7'b0, BUSY},      {7'b0, (e < 7)});
         chk("xfer_data",  {4'b0, CDC_DATA},  {4'b0, d});
      end
   endtask

   initial begin
      DPRESETn   = 1'b0;
      LOAD_VALID = 1'b0;
      LOAD_DATA  = 4'h0;
      ABORT      = 1'b0;
      ack_loop   = 1'b1;
      ack_force  = 1'b0;
      p0_rstn    = 1'b0;
      p0_valid   = 1'b0;
      p0_data    = 4'h0;
      p0_abort   = 1'b0;
      p0_ack     = 1'b0;

      tick();
      tick();
      chk("rst_data",  {4'b0, CDC_DATA}, 8'h0);
      chk("rst_maskn", {7'b0, CDC_MASKn}, 8'h0);
      chk("rst_req",   {7'b0, CDC_REQ}, 8'h0);
      chk("rst_busy",  {7'b0, BUSY}, 8'h0);
      chk("rst_done",  {7'b0, DONE}, 8'h0);
      DPRESETn = 1'b1;
      tick();
      chk("idle_ready", {7'b0, LOAD_READY}, 8'h1);
      chk_en = 1'b1;

      // Basic looped-back transfer of 4'hA.
      do_xfer(4'hA, 1'b0);
      tick();
      chk("after_a_done", {7'b0, DONE}, 8'h0);

      // Abort in SETUP: no request, no DONE, data register keeps 4'h5.
      LOAD_VALID = 1'b1;
      LOAD_DATA  = 4'h5;
      tick();
      LOAD_VALID = 1'b0;
      ABORT      = 1'b1;
      chk("abort_setup_data", {4'b0, CDC_DATA}, 8'h5);
      tick();
      ABORT = 1'b0;
      chk("abort_busy",  {7'b0, BUSY}, 8'h0);
      chk("abort_maskn", {7'b0, CDC_MASKn}, 8'h0);
      chk("abort_ready", {7'b0, LOAD_READY}, 8'h1);
      chk("abort_data",  {4'b0, CDC_DATA}, 8'h5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("abort_no_done", {7'b0, DONE}, 8'h0);
         chk("abort_no_req",  {7'b0, CDC_REQ}, 8'h0);
      end
      do_xfer(4'h3, 1'b0);

      // Back-to-back loads; first one also carries ABORT in IDLE, which must be ignored.
      do_xfer(4'h1, 1'b1);
      do_xfer(4'hF, 1'b0);
      tick();

      // Stall in REQ with ACK low while the load inputs churn.
      ack_loop  = 1'b0;
      ack_force = 1'b0;
      LOAD_VALID = 1'b1;
      LOAD_DATA  = 4'h9;
      tick();
      tick();
      for (int i = 0; i < 20; i++) begin
         LOAD_VALID = i[0];
         LOAD_DATA  = i[3:0];
         tick();
         chk("stall_data",  {4'b0, CDC_DATA}, 8'h9);
         chk("stall_maskn", {7'b0, CDC_MASKn}, 8'h1);
         chk("stall_ready", {7'b0, LOAD_READY}, 8'h0);
      end
      LOAD_VALID = 1'b0;

      // Reset while in REQ with ACK asserted.
      ack_force = 1'b1;
      tick();
      DPRESETn = 1'b0;
      tick();
      DPRESETn = 1'b1;
      chk("mid_rst_data",  {4'b0, CDC_DATA}, 8'h0);
      chk("mid_rst_maskn", {7'b0, CDC_MASKn}, 8'h0);
      chk("mid_rst_req",   {7'b0, CDC_REQ}, 8'h0);
      chk("mid_rst_busy",  {7'b0, BUSY}, 8'h0);
      chk("mid_rst_done",  {7'b0, DONE}, 8'h0);
      tick();
      tick();
      chk("stale_ack_ready", {7'b0, LOAD_READY}, 8'h0);
      ack_force = 1'b0;
      tick();
      chk("stale_ack_ready_1", {7'b0, LOAD_READY}, 8'h0);
      tick();
      chk("stale_ack_cleared", {7'b0, LOAD_READY}, 8'h1);
      chk("stale_ack_no_done", {7'b0, DONE}, 8'h0);

      // PRESENT=0 instance: every output stays 0 under random stimulus.
      for (int i = 0; i < 24; i++) begin
         p0_rstn  = ($urandom_range(0, 3) != 0);
         p0_valid = $urandom_range(0, 1);
         p0_data  = 4'($urandom_range(0, 15));
         p0_abort = $urandom_range(0, 1);
         p0_ack   = $urandom_range(0, 1);
         tick();
         chk("absent_outputs",
             {p0_ready, p0_maskn, p0_req, p0_busy, p0_done, 3'b0} | {4'b0, p0_cdc_data}, 8'h0);
      end

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
